bpm_display: RTL and testbench

BPM_DISPLAY -- requirements
Module: bpm_display

---
 rtl/bpm_display.sv | 153 +++++++++++++++
 tb/tb_bpm_display.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/bpm_display.sv
// ---------------------------------------------------------------------------
// bpm_display
// Multiplexed three-digit 7-segment driver for a heart-rate (BPM) readout.
// A prescaler produces a scan tick every REFRESH_DIV clocks; each tick
// advances the displayed digit position 0->1->2->0. The BCD inputs are
// captured only at the 2->0 frame wrap, so a frame never mixes old and new
// digits. Leading zeros of digits 2 and 1 are blanked, and values 10-15
// show a dash. A heartbeat pulse lights the decimal point on digit 0 for
// DP_HOLD scan ticks.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   d2     in   [3:0] BCD hundreds digit
//   d1     in   [3:0] BCD tens digit
//   d0     in   [3:0] BCD ones digit
//   pulse  in   one-cycle heartbeat strobe
//   an_n   out  [7:0] digit anodes, active-low, bit i = position i
//   seg_n  out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   dp_n   out  decimal point, active-low
// ---------------------------------------------------------------------------
module bpm_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int DP_HOLD     = 150
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic       pulse,
    output logic [7:0] an_n,
    output logic [6:0] seg_n,
    output logic       dp_n
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int CW = $clog2(DP_HOLD + 1);

    localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(DP_HOLD);

    localparam logic [1:0] IDX0 = 2'd0;
    localparam logic [1:0] IDX1 = 2'd1;
    localparam logic [1:0] IDX2 = 2'd2;

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [3:0]    h2, h1, h0;
    logic [CW-1:0] hold;

    logic          tick;
    logic [1:0]    idx_nx;
    logic [3:0]    h2_nx, h1_nx, h0_nx;
    logic [CW-1:0] hold_nx;
    logic [3:0]    cur;
    logic          blank;
    logic [7:0]    an_nx;
    logic [6:0]    seg_nx;
    logic          dp_nx;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;   // dash for non-BCD values
        endcase
        return s;
    endfunction

    // Outputs are decoded from the post-tick state so the registered display
    // shows the new digit position in the cycle right after the tick.
    always_comb begin
        tick    = (presc == PRE_LAST);
        idx_nx  = idx;
        h2_nx   = h2;
        h1_nx   = h1;
        h0_nx   = h0;
        if (tick) begin
            if (idx == IDX2) begin
                idx_nx = IDX0;
                h2_nx  = d2;
                h1_nx  = d1;
                h0_nx  = d0;
            end else begin
                idx_nx = idx + 2'd1;
            end
        end

        // Reload takes priority over the tick decrement.
        hold_nx = hold;
        if (pulse)
            hold_nx = HOLD_LOAD;
        else if (tick && hold != '0)
            hold_nx = hold - CW'(1);

        case (idx_nx)
            IDX0: begin
                cur   = h0_nx;
                blank = 1'b0;
            end
            IDX1: begin
                cur   = h1_nx;
                blank = (h2_nx == 4'd0) && (h1_nx == 4'd0);
            end
            default: begin
                cur   = h2_nx;
                blank = (h2_nx == 4'd0);
            end
        endcase

        seg_nx = blank ? 7'h7F : seg_of(cur);
        an_nx  = ~(8'd1 << idx_nx);
        dp_nx  = !((idx_nx == IDX0) && (hold_nx != '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= IDX0;
            h2    <= '0;
            h1    <= '0;
            h0    <= '0;
            hold  <= '0;
            an_n  <= '1;
            seg_n <= '1;
            dp_n  <= 1'b1;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            idx   <= idx_nx;
            h2    <= h2_nx;
            h1    <= h1_nx;
            h0    <= h0_nx;
            hold  <= hold_nx;
            // Anodes stay dark after reset until the first scan tick.
            if (tick) begin
                an_n  <= an_nx;
                seg_n <= seg_nx;
            end
            dp_n  <= dp_nx;
        end
    end

endmodule

// File: tb/tb_bpm_display.sv
module tb_bpm_display;

    localparam int RD = 4;
    localparam int DH = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] d2 = '0, d1 = '0, d0 = '0;
    logic       pulse = 1'b0;
    logic [7:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n;

    bpm_display #(.REFRESH_DIV(RD), .DP_HOLD(DH)) dut (
        .clk(clk), .rst(rst), .d2(d2), .d1(d1), .d0(d0), .pulse(pulse),
        .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state (behavioural, reset values)
    int         m_presc = 0;
    int         m_idx   = 0;
    int         m_held[3] = '{0, 0, 0};   // [0]=ones, [1]=tens, [2]=hundreds
    int         m_cnt   = 0;
    logic [7:0] m_an    = 8'hFF;
    logic [6:0] m_seg   = 7'h7F;
    logic       m_dp    = 1'b1;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic logic [6:0] shown(input int pos, input int h2v, input int h1v, input int h0v);
        int v;
        if (pos == 2 && h2v == 0) return 7'h7F;
        if (pos == 1 && h2v == 0 && h1v == 0) return 7'h7F;
        v = (pos == 2) ? h2v : (pos == 1) ? h1v : h0v;
        if (v > 9) return 7'h3F;
        return seg_tab[v];
    endfunction

    // Advance the model by one clock edge with the inputs currently applied.
    task automatic model_edge();
        bit   tk;
        exp_t e;
        if (rst) begin
            m_presc = 0; m_idx = 0; m_held = '{0, 0, 0}; m_cnt = 0;
            m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1;
        end else begin
            tk = (m_presc == RD - 1);
            m_presc = (m_presc + 1) % RD;
            if (tk) begin
                if (m_idx == 2) begin
                    m_held[2] = int'(d2); m_held[1] = int'(d1); m_held[0] = int'(d0);
                end
                m_idx = (m_idx + 1) % 3;
            end
            if (pulse) m_cnt = DH;
            else if (tk && m_cnt > 0) m_cnt = m_cnt - 1;
            if (tk) begin
                m_an  = 8'hFF & ~(8'h01 << m_idx);
                m_seg = shown(m_idx, m_held[2], m_held[1], m_held[0]);
            end
            m_dp = !(m_idx == 0 && m_cnt != 0);
        end
        e.an = m_an; e.seg = m_seg; e.dp = m_dp;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic [3:0] a2, input logic [3:0] a1,
                        input logic [3:0] a0, input logic p);
        @(negedge clk);
        rst = r; d2 = a2; d1 = a1; d0 = a0; pulse = p;
        model_edge();
    endtask

    function automatic logic [3:0] rdig();
        if ($urandom_range(0, 3) == 0) return 4'd0;
        return 4'($urandom_range(0, 15));
    endfunction

    // Monitor: compare each cycle's registered outputs with the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (an_n !== e.an) begin
                    bad++;
                    $display("FAIL an_n t=%0t got=%h want=%h", $time, an_n, e.an);
                end
                total++;
                if (seg_n !== e.seg) begin
                    bad++;
                    $display("FAIL seg_n t=%0t got=%h want=%h", $time, seg_n, e.seg);
                end
                total++;
                if (dp_n !== e.dp) begin
                    bad++;
                    $display("FAIL dp_n t=%0t got=%b want=%b", $time, dp_n, e.dp);
                end
            end
        end
    end

    logic [3:0] pats [6][3] = '{'{4'h0, 4'h7, 4'h2}, '{4'h1, 4'h0, 4'h5}, '{4'h0, 4'h0, 4'h0},
                                '{4'h0, 4'hC, 4'h3}, '{4'h9, 4'h9, 4'h9}, '{4'hF, 4'h0, 4'h0}};

    initial begin
        logic [3:0] a2, a1, a0;
        for (int i = 0; i < 3; i++) step(1'b1, 4'h0, 4'h0, 4'h0, 1'b0);

        // Fixed digit patterns, each held for several frames, with a heartbeat.
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 40; c++)
                step(1'b0, pats[p][0], pats[p][1], pats[p][2], c == 3);
        end

        // Mid-frame input change, then reset with the dot active.
        for (int c = 0; c < 5; c++) step(1'b0, 4'h3, 4'h4, 4'h5, c == 0);
        for (int c = 0; c < 30; c++) step(1'b0, 4'h8, 4'h6, 4'h1, c == 20);
        step(1'b1, 4'h8, 4'h6, 4'h1, 1'b1);
        for (int c = 0; c < 30; c++) step(1'b0, 4'h2, 4'h0, 4'h9, 1'b0);

        // Randomized traffic.
        a2 = rdig(); a1 = rdig(); a0 = rdig();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                a2 = rdig(); a1 = rdig(); a0 = rdig();
            end
            step($urandom_range(0, 149) == 0, a2, a1, a0, $urandom_range(0, 14) == 0);
        end

        @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
